// File: rtl/adder_pkg.sv
// Shared constants and helpers for the segmented pipelined adder.
package adder_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_SEG   = 4;

    // Number of pipeline stages for a given operand width and segment size.
    function automatic int unsigned num_stages(input int unsigned width, input int unsigned seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/adder_seg.sv
// W-bit combinational ripple-carry segment built from full-adder cells.
module adder_seg
    import adder_pkg::*;
#(
    parameter int unsigned W = DEF_SEG
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    // Ripple the carry through one full-adder cell per bit.
    always_comb begin
        logic c;
        c = ci;
        s = '0;
        for (int unsigned i = 0; i < W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder: one SEG-bit segment per stage, carry registered between
// stages, not-yet-added operand bits carried forward in delay registers.
// The whole pipeline advances unless the output is valid and not accepted.
// Optional signed-overflow output: define PIPELINED_ADDER_OVF_EN.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned STAGES = num_stages(WIDTH, SEG);

    logic w_adv;

    assign in_ready = !(out_valid && !out_ready);
    assign w_adv    = in_ready;

`ifdef PIPELINED_ADDER_OVF_EN
    logic r_ovf;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int unsigned LO = k * SEG;

        // Operand bits not yet consumed, from bit LO upward.
        logic [WIDTH-1:LO]    w_ha;
        logic [WIDTH-1:LO]    w_hb;
        logic                 w_ci;
        logic                 w_vin;
        logic [SEG-1:0]       w_s;
        logic                 w_co;
        logic [LO+SEG-1:0]    w_sum_nx;

        logic                 r_vld;
        logic                 r_c;
        logic [LO+SEG-1:0]    r_sum;

        if (k == 0) begin : g_first
            assign w_ha     = a;
            assign w_hb     = b;
            assign w_ci     = cin;
            assign w_vin    = in_valid;
            assign w_sum_nx = w_s;
        end else begin : g_next
            assign w_ha     = g_st[k-1].g_dly.r_ha;
            assign w_hb     = g_st[k-1].g_dly.r_hb;
            assign w_ci     = g_st[k-1].r_c;
            assign w_vin    = g_st[k-1].r_vld;
            assign w_sum_nx = {w_s, g_st[k-1].r_sum};
        end

        adder_seg #(.W(SEG)) u_seg (
            .a  (w_ha[LO +: SEG]),
            .b  (w_hb[LO +: SEG]),
            .ci (w_ci),
            .s  (w_s),
            .co (w_co)
        );

        // Stage register: valid, carry and accumulated low sum bits.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= '0;
            end else if (w_adv) begin
                r_vld <= w_vin;
                r_c   <= w_co;
                r_sum <= w_sum_nx;
            end
        end

        if (k < STAGES - 1) begin : g_dly
            logic [WIDTH-1:LO+SEG] r_ha;
            logic [WIDTH-1:LO+SEG] r_hb;

            // Skew the higher operand segments toward their stage.
            always_ff @(posedge clk) begin
                if (w_adv) begin
                    r_ha <= w_ha[WIDTH-1:LO+SEG];
                    r_hb <= w_hb[WIDTH-1:LO+SEG];
                end
            end
        end

`ifdef PIPELINED_ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            // Signed overflow from the operand sign bits that reach the last stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= (w_ha[WIDTH-1] == w_hb[WIDTH-1]) &&
                             (w_s[SEG-1] != w_ha[WIDTH-1]);
                end
            end
        end
`endif
    end

    assign sum       = g_st[STAGES-1].r_sum;
    assign cout      = g_st[STAGES-1].r_c;
    assign out_valid = g_st[STAGES-1].r_vld;
`ifdef PIPELINED_ADDER_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=16, SEG=4).
module tb_pipelined_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         out_valid;
    logic         out_ready;
`ifdef PIPELINED_ADDER_OVF_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t q[$];
    int   pop_cyc[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   lat;
    bit   last_acc;

    pipelined_adder #(.WIDTH(16), .SEG(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid),
`ifdef PIPELINED_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [W:0] t;
        exp_t       e;
        t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.s = t[W-1:0];
        e.c = t[W];
        e.o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return e;
    endfunction

    // One clock: score handshakes mid-cycle, then step past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_acc = 1'b0;
        if (out_valid && out_ready) begin
            chk("output_has_expected_entry", {31'b0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sum", {16'b0, sum}, {16'b0, e.s});
                chk("cout", {31'b0, cout}, {31'b0, e.c});
`ifdef PIPELINED_ADDER_OVF_EN
                chk("ovf", {31'b0, ovf}, {31'b0, e.o});
`endif
                pop_cyc.push_back(cyc);
            end
        end
        if (in_valid && in_ready && !rst) begin
            q.push_back(model(a, b, cin));
            last_acc = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && q.size() > 0; i++) tick();
        chk("drain_left", q.size(), 0);
    endtask

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        a        = x;
        b        = y;
        cin      = ci;
        in_valid = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_sum", {16'b0, sum}, 0);
        chk("rst_cout", {31'b0, cout}, 0);
`ifdef PIPELINED_ADDER_OVF_EN
        chk("rst_ovf", {31'b0, ovf}, 0);
`endif
        rst = 1'b0;
        chk("in_ready_after_rst", {31'b0, in_ready}, 1);

        // Zero operands and latency.
        drive(16'h0000, 16'h0000, 1'b0);
        tick();
        chk("zero_accepted", {31'b0, last_acc}, 1);
        in_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 10 && !out_valid; i++) begin
            tick();
            lat++;
        end
        chk("latency", lat, 4);
        drain(10);

        // Full carry propagation and a carry-in case.
        drive(16'hFFFF, 16'h0001, 1'b0);
        tick();
        drive(16'h1234, 16'h1111, 1'b1);
        tick();
        in_valid = 1'b0;
        drain(10);

        // Eight back-to-back transactions.
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom));
            chk("in_ready_b2b", {31'b0, in_ready}, 1);
            tick();
        end
        in_valid = 1'b0;
        drain(20);
        chk("b2b_count", pop_cyc.size(), 8);
        if (pop_cyc.size() == 8) chk("b2b_consecutive", pop_cyc[7] - pop_cyc[0], 7);

        // Stall with a full pipeline.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom));
            tick();
        end
        drive(16'($urandom), 16'($urandom), 1'($urandom));
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", {31'b0, in_ready}, 0);
            chk("stall_out_valid", {31'b0, out_valid}, 1);
            chk("stall_sum", {16'b0, sum}, {16'b0, q[0].s});
            chk("stall_cout", {31'b0, cout}, {31'b0, q[0].c});
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("simul_in_out", {31'b0, last_acc}, 1);
        in_valid = 1'b0;
        drain(20);

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom));
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        chk("in_ready_after_rst2", {31'b0, in_ready}, 1);
        for (int i = 0; i < 4; i++) begin
            chk("flushed_out_valid", {31'b0, out_valid}, 0);
            tick();
        end
        drive(16'hABCD, 16'h1357, 1'b1);
        tick();
        in_valid = 1'b0;
        drain(10);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 80; i++) begin
            if (!in_valid || last_acc) begin
                a        = 16'($urandom);
                b        = 16'($urandom);
                cin      = 1'($urandom);
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(40);

`ifdef PIPELINED_ADDER_OVF_EN
        drive(16'h7FFF, 16'h0001, 1'b0);
        tick();
        drive(16'hFFFF, 16'h0001, 1'b0);
        tick();
        in_valid = 1'b0;
        drain(10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
